mult_ctrl: RTL and testbench
============================

MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width; the product is 2*WIDTH bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request to begin a signed multiply of op_a by op_b.
REQ-005 The block SHALL have port op_a, input, WIDTH, signed multiplier (Booth-scanned operand).
REQ-006 The block SHALL have port op_b, input, WIDTH, signed multiplicand.
REQ-007 The block SHALL have port flush, input, 1, abort of the in-flight multiply (pipeline squash).
REQ-008 The block SHALL have port rd_hilo, input, 1, pipeline is reading HI or LO this cycle.
REQ-009 The block SHALL have port busy, output, 1, a multiply is in progress.
REQ-010 The block SHALL have port done, output, 1, single-cycle pulse: HI/LO were written this cycle.
REQ-011 The block SHALL have port stall, output, 1, pipeline must hold.
REQ-012 The block SHALL have ports hi and lo, output, WIDTH each, the architectural HI/LO registers.

Function
REQ-013 The block SHALL implement states IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, start=1 with flush=0 SHALL latch op_a, op_b, clear the accumulator and Booth bit E, zero the step counter and enter RUN next cycle.
REQ-015 In RUN, each cycle SHALL perform one radix-2 Booth step on pair {multiplier[i], E}: 10 subtracts op_b, 01 adds op_b, 00/11 no add, into the upper WIDTH+1 accumulator bits, then arithmetic right shift by one.
REQ-016 Accumulator arithmetic SHALL be WIDTH+1 bits wide so -2^(WIDTH-1) * -2^(WIDTH-1) is exact; no post-correction step is permitted.
REQ-017 After WIDTH RUN cycles the block SHALL enter DONE, write hi=product[2W-1:W], lo=product[W-1:0] and assert done for exactly that cycle.
REQ-018 Latency SHALL be WIDTH+1 cycles from start-accept edge to done (17 for WIDTH=16).
REQ-019 DONE SHALL return to IDLE next cycle unless a new start is accepted (back-to-back allowed).
REQ-020 busy SHALL be 1 exactly in RUN.
REQ-021 stall SHALL equal busy AND (rd_hilo OR start); start while busy is not queued, the requester holds it.
REQ-022 flush in RUN SHALL return to IDLE next cycle with hi/lo unchanged and no done pulse.
REQ-023 flush together with start SHALL win: no multiply starts.
REQ-024 flush in DONE SHALL NOT undo the HI/LO write already made.
REQ-025 hi/lo SHALL change only on the DONE write or reset.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, hi=0, lo=0, busy=0, done=0, stall=0, counter and accumulator 0, from any state including mid-RUN.
REQ-027 A start sampled on the same edge as rst_n=0 SHALL be ignored.

Structure
REQ-028 State enum, WIDTH default and the step-count constant SHALL live in the shared mips_pkg package.
REQ-029 The single Booth add/shift step SHALL be a combinational sub-module booth_step; mult_ctrl holds FSM, counter, operand latches and HI/LO.

Verification
REQ-030 op_a=3, op_b=-5, start one cycle -> done 17 cycles later, hi=16'hFFFF, lo=16'hFFF1.
REQ-031 op_a=op_b=16'h8000 -> hi=16'h4000, lo=16'h0000.
REQ-032 hi/lo hold 16'h0001/16'h0002, start 7x9, flush at RUN cycle 8 -> IDLE next cycle, no done, hi/lo still 16'h0001/16'h0002.
REQ-033 start 100x200 and rd_hilo=1 during RUN -> stall=1 every RUN cycle; second start while busy ignored; result hi=16'h0000, lo=16'h4E20.
REQ-034 start in DONE cycle with new operands -2x4 -> back-to-back run, second done 17 cycles later, lo=16'hFFF8, hi=16'hFFFF.
REQ-035 rst_n=0 at RUN cycle 5 -> next cycle IDLE, hi=lo=0, busy=0, no done pulse.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared multiplier definitions: FSM states, default operand width and Booth step count.
package mips_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int MULT_STEPS = WIDTH_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

  // One radix-2 Booth step retires one multiplier bit.
  function automatic int mult_steps(input int width);
    return width;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth add/shift on {acc, multiplier, E}; purely combinational.
module booth_step
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] mplr_i,
  input  logic             e_i,
  input  logic [WIDTH-1:0] mcand_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] mplr_o,
  output logic             e_o
);

  logic [WIDTH:0] mcand_x;
  logic [WIDTH:0] sum;

  always_comb begin
    mcand_x = {mcand_i[WIDTH-1], mcand_i};
    case ({mplr_i[0], e_i})
      2'b10:   sum = acc_i - mcand_x;
      2'b01:   sum = acc_i + mcand_x;
      default: sum = acc_i;
    endcase
    // Arithmetic shift of the whole {acc, multiplier, E} chain by one.
    acc_o  = {sum[WIDTH], sum[WIDTH:1]};
    mplr_o = {sum[0], mplr_i[WIDTH-1:1]};
    e_o    = mplr_i[0];
  end

endmodule

// File: rtl/mult_ctrl.sv
// Sequential signed Booth multiplier with HI/LO; WIDTH+1 cycles start-accept to done.
// Starts while busy are not queued: stall holds the pipeline, flush squashes a run.
module mult_ctrl
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  input  logic             rd_hilo,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int STEPS = mult_steps(WIDTH);
  localparam int CW    = $clog2(STEPS) + 1;

  mult_state_e      state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic             e_q, e_d;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .mplr_i  (mplr_q),
    .e_i     (e_q),
    .mcand_i (mcand_q),
    .acc_o   (acc_d),
    .mplr_o  (mplr_d),
    .e_o     (e_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      e_q     <= 1'b0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (flush) begin
            state_q <= ST_IDLE;
          end else begin
            acc_q  <= acc_d;
            mplr_q <= mplr_d;
            e_q    <= e_d;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CW'(STEPS - 1)) begin
              state_q <= ST_DONE;
              hi_q    <= acc_d[WIDTH-1:0];
              lo_q    <= mplr_d;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          // IDLE and DONE both accept a new multiply; flush always wins.
          if (start && !flush) begin
            state_q <= ST_RUN;
            mplr_q  <= op_a;
            mcand_q <= op_b;
            acc_q   <= '0;
            e_q     <= 1'b0;
            cnt_q   <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign done  = done_q;
  assign stall = busy & (rd_hilo | start);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mult_ctrl.sv
module tb_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        flush;
  logic        rd_hilo;
  logic        busy;
  logic        done;
  logic        stall;
  logic [15:0] hi;
  logic [15:0] lo;

  int errors = 0;
  int checks = 0;

  mult_ctrl #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .flush   (flush),
    .rd_hilo (rd_hilo),
    .busy    (busy),
    .done    (done),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present start for one edge (the accept edge); returns 1 ns after it.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    tick();
    start = 1'b0;
  endtask

  // Counts edges from the accept edge (inclusive) until done is seen.
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; op_a = 16'd3; op_b = 16'd3; flush = 1'b0; rd_hilo = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, done, stall} !== 3'b000) begin
      errors++; $display("FAIL reset_ctl: busy/done/stall=%b required 000", {busy, done, stall});
    end
    checks++;
    if (hi !== 16'h0000 || lo !== 16'h0000) begin
      errors++; $display("FAIL reset_hilo: hi=%h lo=%h required 0000/0000", hi, lo);
    end
    start = 1'b0; rd_hilo = 1'b0; rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_start_ignored: busy=%b required 0", busy);
    end
  endtask

  task automatic test_basic();
    int lat;
    issue(16'd3, 16'hFFFB);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy: busy=%b required 1", busy);
    end
    wait_done(lat);
    checks++;
    if (lat != 17) begin
      errors++; $display("FAIL basic_latency: %0d edges required 17", lat);
    end
    checks++;
    if (hi !== 16'hFFFF || lo !== 16'hFFF1) begin
      errors++; $display("FAIL basic_result: hi=%h lo=%h required ffff/fff1", hi, lo);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_pulse: done=%b busy=%b required 0/0", done, busy);
    end
  endtask

  task automatic test_min_neg();
    int lat;
    issue(16'h8000, 16'h8000);
    wait_done(lat);
    checks++;
    if (hi !== 16'h4000 || lo !== 16'h0000 || lat != 17) begin
      errors++; $display("FAIL min_neg: hi=%h lo=%h lat=%0d required 4000/0000 lat 17", hi, lo, lat);
    end
    tick();
  endtask

  task automatic test_flush();
    int lat;
    int seen;
    issue(16'd198, 16'd331);
    wait_done(lat);
    checks++;
    if (hi !== 16'h0001 || lo !== 16'h0002) begin
      errors++; $display("FAIL flush_setup: hi=%h lo=%h required 0001/0002", hi, lo);
    end
    tick();
    issue(16'd7, 16'd9);
    for (int i = 1; i < 8; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL flush_run: busy=%b done=%b required 0/0", busy, done);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen != 0 || hi !== 16'h0001 || lo !== 16'h0002) begin
      errors++; $display("FAIL flush_hold: activity=%0d hi=%h lo=%h required 0 0001/0002", seen, hi, lo);
    end
    start = 1'b1; flush = 1'b1; op_a = 16'd2; op_b = 16'd2;
    tick();
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_beats_start: busy=%b required 0", busy);
    end
  endtask

  task automatic test_stall();
    int bad;
    issue(16'd100, 16'd200);
    rd_hilo = 1'b1;
    bad = 0;
    for (int i = 1; i <= 16; i++) begin
      if (busy !== 1'b1 || stall !== 1'b1) bad++;
      if (i == 3) begin start = 1'b1; op_a = 16'd5; op_b = 16'd5; end
      if (i == 6) start = 1'b0;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stall_run: %0d RUN cycles without busy&stall required 0", bad);
    end
    checks++;
    if (done !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL stall_done: done=%b stall=%b required 1/0", done, stall);
    end
    checks++;
    if (hi !== 16'h0000 || lo !== 16'h4E20) begin
      errors++; $display("FAIL stall_result: hi=%h lo=%h required 0000/4e20", hi, lo);
    end
    rd_hilo = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL stall_no_queue: busy=%b required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(16'd6, 16'd7);
    wait_done(lat);
    checks++;
    if (done !== 1'b1 || hi !== 16'h0000 || lo !== 16'h002A) begin
      errors++; $display("FAIL b2b_first: done=%b hi=%h lo=%h required 1 0000/002a", done, hi, lo);
    end
    issue(16'hFFFE, 16'd4);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_restart: busy=%b done=%b required 1/0", busy, done);
    end
    wait_done(lat);
    checks++;
    if (lat != 17 || hi !== 16'hFFFF || lo !== 16'hFFF8) begin
      errors++; $display("FAIL b2b_second: lat=%0d hi=%h lo=%h required 17 ffff/fff8", lat, hi, lo);
    end
    start = 1'b1; flush = 1'b1; op_a = 16'd1; op_b = 16'd1;
    tick();
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 16'hFFFF || lo !== 16'hFFF8) begin
      errors++; $display("FAIL flush_in_done: busy=%b hi=%h lo=%h required 0 ffff/fff8", busy, hi, lo);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    issue(16'd7, 16'd9);
    for (int i = 1; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 16'h0000 || lo !== 16'h0000) begin
      errors++; $display("FAIL reset_mid_run: busy=%b done=%b hi=%h lo=%h required 0 0 0000/0000", busy, done, hi, lo);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL reset_mid_quiet: activity=%0d required 0", seen);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; flush = 1'b0; rd_hilo = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_min_neg();
    test_flush();
    test_stall();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
